usb_rx_pkt_assembler: RTL and testbench

Receive-side packet assembler that sits directly downstream of `usb_top`. It consumes the received byte stream (`DATA`, `RX_READY_LD`, `RX_LAST_BYTE`, `error_crc_rx`) and validates the PID byte. It buffers each packet's remaining bytes and presents only good, complete packets to the function/endpoint logic through a show-ahead read port. It drives `usb_top.RX_LOAD` to throttle reception while a packet is held unread.

---
 rtl/usb_pkg.sv | 31 +++
 rtl/usb_rx_pkt_ram.sv | 24 ++
 rtl/usb_rx_pkt_assembler.sv | 187 ++++++++++++++++++
 tb/tb_usb_rx_pkt_assembler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - PID, error-code and state constants for the USB receive path
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_PID      = 3'd1,
    ERR_CRC      = 3'd2,
    ERR_OVERFLOW = 3'd3,
    ERR_OVERRUN  = 3'd4
  } err_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Upper nibble of a PID byte must be the complement of the lower nibble.
  function automatic logic pid_ok(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/usb_rx_pkt_ram.sv
// rtl/usb_rx_pkt_ram.sv - packet payload buffer, synchronous write, asynchronous read
module usb_rx_pkt_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/usb_rx_pkt_assembler.sv
// rtl/usb_rx_pkt_assembler.sv - validates and buffers received USB packets, presents good ones via a show-ahead port
module usb_rx_pkt_assembler
  import usb_pkg::*;
#(
  parameter int MAX_BYTES = 64,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             gclk,
  input  logic             reset_l,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready_ld,
  input  logic             rx_last_byte,
  input  logic             error_crc_rx,
  output logic             rx_load,
  output logic             pkt_valid,
  output logic [3:0]       pkt_pid,
  output logic [LEN_W-1:0] pkt_len,
  output logic [7:0]       rd_data,
  output logic             rd_last,
  input  logic             rd_en,
  output logic [2:0]       err_code,
  output logic [7:0]       drop_cnt
);

  localparam int AW = $clog2(MAX_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] wptr_q, wptr_d;
  logic [LEN_W-1:0] rptr_q, rptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       pid_q, pid_d;
  logic [2:0]       err_q, err_d;
  logic [7:0]       drop_q, drop_d;
  logic             ovr_q, ovr_d;

  logic       last_stb;
  logic       rec_err;
  err_e       rec_code;
  logic       ram_we;
  logic [7:0] ram_rdata;

  assign last_stb = rx_ready_ld & rx_last_byte;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    len_d    = len_q;
    pid_d    = pid_q;
    err_d    = err_q;
    drop_d   = drop_q;
    ovr_d    = ovr_q;
    rec_err  = 1'b0;
    rec_code = ERR_NONE;
    ram_we   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_ready_ld) begin
          if (!pid_ok(rx_data)) begin
            rec_err  = 1'b1;
            rec_code = ERR_PID;
            state_d  = rx_last_byte ? ST_IDLE : ST_DROP;
          end else if (rx_last_byte) begin
            if (error_crc_rx) begin
              rec_err  = 1'b1;
              rec_code = ERR_CRC;
            end else begin
              pid_d   = rx_data[3:0];
              len_d   = '0;
              rptr_d  = '0;
              state_d = ST_HOLD;
            end
          end else begin
            pid_d   = rx_data[3:0];
            wptr_d  = '0;
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (rx_ready_ld) begin
          if (wptr_q == MAX_LEN) begin
            rec_err  = 1'b1;
            rec_code = ERR_OVERFLOW;
            state_d  = rx_last_byte ? ST_IDLE : ST_DROP;
          end else begin
            ram_we = 1'b1;
            wptr_d = wptr_q + ONE;
            if (rx_last_byte) begin
              if (error_crc_rx) begin
                rec_err  = 1'b1;
                rec_code = ERR_CRC;
                state_d  = ST_IDLE;
              end else begin
                len_d   = wptr_q + ONE;
                rptr_d  = '0;
                state_d = ST_HOLD;
              end
            end
          end
        end
      end
      ST_DROP: begin
        if (last_stb) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (rd_en) begin
          if (rd_last) begin
            rptr_d  = '0;
            state_d = ST_IDLE;
          end else begin
            rptr_d = rptr_q + ONE;
          end
        end
        // One overrun record per incoming packet, however many bytes it carries.
        if (rx_ready_ld) begin
          ovr_d = 1'b1;
          if (!ovr_q) begin
            rec_err  = 1'b1;
            rec_code = ERR_OVERRUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (last_stb) begin
      ovr_d = 1'b0;
    end

    if (rec_err) begin
      err_d = rec_code;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      len_q   <= '0;
      pid_q   <= '0;
      err_q   <= '0;
      drop_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      len_q   <= len_d;
      pid_q   <= pid_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      ovr_q   <= ovr_d;
    end
  end

  usb_rx_pkt_ram #(
    .DEPTH(MAX_BYTES),
    .AW   (AW)
  ) u_ram (
    .clk  (gclk),
    .we   (ram_we),
    .waddr(wptr_q[AW-1:0]),
    .wdata(rx_data),
    .raddr(rptr_q[AW-1:0]),
    .rdata(ram_rdata)
  );

  assign pkt_valid = (state_q == ST_HOLD);
  assign rx_load   = (state_q != ST_HOLD);
  assign pkt_pid   = pid_q;
  assign pkt_len   = len_q;
  assign rd_data   = (pkt_valid && len_q != '0) ? ram_rdata : 8'h00;
  assign rd_last   = pkt_valid && ((len_q == '0) || (rptr_q == len_q - ONE));
  assign err_code  = err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_usb_rx_pkt_assembler.sv
// tb/tb_usb_rx_pkt_assembler.sv - self-checking bench for usb_rx_pkt_assembler
module tb_usb_rx_pkt_assembler;

  localparam int MAXB  = 4;
  localparam int LEN_W = $clog2(MAXB + 1);

  logic             gclk = 1'b0;
  logic             reset_l;
  logic [7:0]       rx_data;
  logic             rx_ready_ld;
  logic             rx_last_byte;
  logic             error_crc_rx;
  logic             rx_load;
  logic             pkt_valid;
  logic [3:0]       pkt_pid;
  logic [LEN_W-1:0] pkt_len;
  logic [7:0]       rd_data;
  logic             rd_last;
  logic             rd_en;
  logic [2:0]       err_code;
  logic [7:0]       drop_cnt;

  usb_rx_pkt_assembler #(.MAX_BYTES(MAXB)) dut (
    .gclk        (gclk),
    .reset_l     (reset_l),
    .rx_data     (rx_data),
    .rx_ready_ld (rx_ready_ld),
    .rx_last_byte(rx_last_byte),
    .error_crc_rx(error_crc_rx),
    .rx_load     (rx_load),
    .pkt_valid   (pkt_valid),
    .pkt_pid     (pkt_pid),
    .pkt_len     (pkt_len),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .rd_en       (rd_en),
    .err_code    (err_code),
    .drop_cnt    (drop_cnt)
  );

  always #5 gclk = ~gclk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: tracks the committed packet and which byte of the
  // current incoming packet is being seen, and decides outcomes from that.
  bit         exp_valid;
  logic [3:0] exp_pid;
  logic [7:0] exp_bytes[$];
  int         exp_rptr;
  int         exp_err;
  int         exp_drop;
  int         pkt_idx;
  bit         ignoring;
  logic [3:0] cur_pid;
  logic [7:0] cur_q[$];

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_pid   = '0;
    exp_bytes.delete();
    exp_rptr  = 0;
    exp_err   = 0;
    exp_drop  = 0;
    pkt_idx   = 0;
    ignoring  = 1'b0;
    cur_q.delete();
  endtask

  task automatic rec(input int code);
    exp_err = code;
    if (exp_drop < 255) exp_drop++;
  endtask

  task automatic model(input logic stb, input logic [7:0] d, input logic last,
                       input logic crc, input logic rd);
    bit held;
    held = exp_valid;
    if (rd && exp_valid) begin
      if (exp_bytes.size() == 0 || exp_rptr == exp_bytes.size() - 1) begin
        exp_valid = 1'b0;
        exp_rptr  = 0;
      end else begin
        exp_rptr++;
      end
    end
    if (stb) begin
      if (pkt_idx == 0) begin
        cur_q.delete();
        cur_pid = d[3:0];
        if (held) begin
          ignoring = 1'b1;
          rec(4);
        end else if (d[7:4] != ~d[3:0]) begin
          ignoring = 1'b1;
          rec(1);
        end else begin
          ignoring = 1'b0;
        end
      end else if (!ignoring) begin
        if (pkt_idx > MAXB) begin
          ignoring = 1'b1;
          rec(3);
        end else begin
          cur_q.push_back(d);
        end
      end
      if (last) begin
        if (!ignoring) begin
          if (crc) rec(2);
          else begin
            exp_valid = 1'b1;
            exp_pid   = cur_pid;
            exp_bytes = cur_q;
            exp_rptr  = 0;
          end
        end
        pkt_idx = 0;
      end else begin
        pkt_idx++;
      end
    end
  endtask

  always @(negedge gclk) begin
    if (chk_en) begin
      chk("rx_load", int'(rx_load), int'(!exp_valid));
      chk("pkt_valid", int'(pkt_valid), int'(exp_valid));
      chk("err_code", int'(err_code), exp_err);
      chk("drop_cnt", int'(drop_cnt), exp_drop);
      if (exp_valid) begin
        chk("pkt_pid", int'(pkt_pid), int'(exp_pid));
        chk("pkt_len", int'(pkt_len), exp_bytes.size());
        chk("rd_data", int'(rd_data), (exp_bytes.size() == 0) ? 0 : int'(exp_bytes[exp_rptr]));
        chk("rd_last", int'(rd_last),
            int'(exp_bytes.size() == 0 || exp_rptr == exp_bytes.size() - 1));
      end
    end
  end

  task automatic step(input logic stb, input logic [7:0] d, input logic last,
                      input logic crc, input logic rd);
    rx_ready_ld  = stb;
    rx_data      = d;
    rx_last_byte = last;
    error_crc_rx = crc;
    rd_en        = rd;
    @(posedge gclk);
    #1;
    model(stb, d, last, crc, rd);
    rx_ready_ld  = 1'b0;
    rx_data      = 8'h00;
    rx_last_byte = 1'b0;
    error_crc_rx = 1'b0;
    rd_en        = 1'b0;
  endtask

  // Bytes are packed most-significant first: byte 0 is the PID.
  task automatic send(input int n, input logic [63:0] bytes, input logic crc, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bytes[(n-1-i)*8 +: 8], i == n - 1, crc && (i == n - 1), 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic rd_pulse();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_rx_load"}, int'(rx_load), 1);
    chk({tag, "_pkt_valid"}, int'(pkt_valid), 0);
    chk({tag, "_pkt_pid"}, int'(pkt_pid), 0);
    chk({tag, "_pkt_len"}, int'(pkt_len), 0);
    chk({tag, "_rd_data"}, int'(rd_data), 0);
    chk({tag, "_rd_last"}, int'(rd_last), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_drop_cnt"}, int'(drop_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l      = 1'b0;
    rx_data      = 8'h00;
    rx_ready_ld  = 1'b0;
    rx_last_byte = 1'b0;
    error_crc_rx = 1'b0;
    rd_en        = 1'b0;
    model_reset();
    repeat (3) @(posedge gclk);
    #1;
    reset_outputs_check("reset");
    reset_l = 1'b1;
    chk_en  = 1'b1;

    // DATA0 with three payload bytes
    send(4, 64'hC3803FB4, 1'b0, 0);
    chk("t1_valid", int'(pkt_valid), 1);
    chk("t1_rx_load", int'(rx_load), 0);
    chk("t1_pid", int'(pkt_pid), 3);
    chk("t1_len", int'(pkt_len), 3);
    chk("t1_byte0", int'(rd_data), 8'h80);
    idle(1);
    rd_pulse();
    chk("t1_byte1", int'(rd_data), 8'h3F);
    rd_pulse();
    chk("t1_byte2", int'(rd_data), 8'hB4);
    chk("t1_last", int'(rd_last), 1);
    rd_pulse();
    chk("t1_released", int'(pkt_valid), 0);

    // ACK handshake
    send(1, 64'hD2, 1'b0, 0);
    chk("t2_pid", int'(pkt_pid), 2);
    chk("t2_len", int'(pkt_len), 0);
    chk("t2_rd_last", int'(rd_last), 1);
    chk("t2_rd_data", int'(rd_data), 0);
    rd_pulse();
    chk("t2_released", int'(pkt_valid), 0);

    // Bad PID followed by three bytes, with gaps between strobes
    send(4, 64'h3F010203, 1'b0, 1);
    chk("t3_err", int'(err_code), 1);
    chk("t3_drop", int'(drop_cnt), 1);
    chk("t3_rx_load", int'(rx_load), 1);

    // CRC failure on the last byte
    send(5, 64'hC311223344, 1'b1, 0);
    chk("t4_err", int'(err_code), 2);
    chk("t4_valid", int'(pkt_valid), 0);

    // Overflow on the fifth payload byte, sixth byte dropped
    send(7, 64'hC3010203040506, 1'b0, 0);
    chk("t5_err", int'(err_code), 3);
    chk("t5_drop", int'(drop_cnt), 3);
    chk("t5_valid", int'(pkt_valid), 0);

    // Exactly MAX_BYTES payload bytes fit
    send(5, 64'hC30A0B0C0D, 1'b0, 0);
    chk("t6_len", int'(pkt_len), 4);
    idle(2);

    // New packet while holding: one overrun record, held data untouched
    send(4, 64'h4B112233, 1'b0, 0);
    chk("t7_err", int'(err_code), 4);
    chk("t7_drop", int'(drop_cnt), 4);
    chk("t7_byte0", int'(rd_data), 8'h0A);
    for (int i = 0; i < 4; i++) rd_pulse();
    chk("t7_released", int'(pkt_valid), 0);

    // Strobe in the releasing cycle is an overrun; next cycle is a new PID
    send(1, 64'hD2, 1'b0, 0);
    step(1'b1, 8'hD2, 1'b1, 1'b0, 1'b1);
    chk("t8_err", int'(err_code), 4);
    chk("t8_drop", int'(drop_cnt), 5);
    chk("t8_released", int'(pkt_valid), 0);
    send(1, 64'h5A, 1'b0, 0);
    chk("t8_nak_pid", int'(pkt_pid), 4'hA);
    rd_pulse();

    // Asynchronous reset while receiving
    send(1, 64'hC3, 1'b0, 0);
    step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    #3 reset_l = 1'b0;
    #1;
    reset_outputs_check("midreset");
    model_reset();
    @(posedge gclk);
    #2 reset_l = 1'b1;
    chk_en = 1'b1;
    send(1, 64'h69, 1'b0, 0);
    chk("t9_pid", int'(pkt_pid), 4'h9);
    chk("t9_valid", int'(pkt_valid), 1);
    rd_pulse();

    // Drop counter saturation
    for (int i = 0; i < 260; i++) send(1, 64'hFF, 1'b0, 0);
    chk("t10_drop_sat", int'(drop_cnt), 255);
    chk("t10_err", int'(err_code), 1);
    idle(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
